// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and default timing constants for the VGA
//                scan-out path (BGR555 colour, pipeline control word,
//                GBA image on a 640x480-style raster).
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default raster timing (clock cycles horizontally, lines vertically)
  localparam int DEF_H_TOTAL     = 1596;
  localparam int DEF_H_PW        = 190;
  localparam int DEF_H_BP        = 95;
  localparam int DEF_H_DISP      = 1280;
  localparam int DEF_V_TOTAL     = 528;
  localparam int DEF_V_PW        = 2;
  localparam int DEF_V_BP        = 36;
  localparam int DEF_V_DISP      = 480;
  localparam int DEF_CLK_PER_DOT = 2;

  // Default source image (GBA) and scan-out options
  localparam int DEF_SRC_COLS    = 240;
  localparam int DEF_SRC_ROWS    = 160;
  localparam int DEF_SCALE       = 2;
  localparam int DEF_RD_LAT      = 1;
  localparam int DEF_ADDR_W      = 17;

  // BGR555 colour word: blue in the top field, red in the bottom field
  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } bgr555_t;

  // Per-cycle control word carried alongside the frame-buffer read
  typedef struct packed {
    logic active;   // inside the visible raster
    logic image;    // inside the image and enabled: use read data
    logic hs;       // raw hsync, active low
    logic vs;       // raw vsync, active low
    logic fs;       // first cycle of the frame
  } scan_ctl_t;

  // Control word value that drives every output to its idle level
  localparam scan_ctl_t SCAN_CTL_IDLE = '{active: 1'b0, image: 1'b0,
                                         hs: 1'b1, vs: 1'b1, fs: 1'b0};

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Raster counters with raw active-low syncs, active-area
//                flags and dot / line / frame strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_PW        = DEF_H_PW,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_DISP      = DEF_H_DISP,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_PW        = DEF_V_PW,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_DISP      = DEF_V_DISP,
  parameter int CLK_PER_DOT = DEF_CLK_PER_DOT
) (
  input  logic clock,
  input  logic reset_n,
  output logic hs_raw,
  output logic vs_raw,
  output logic h_active,
  output logic v_active,
  output logic dot_end,
  output logic line_end,
  output logic frame_end,
  output logic frame_first
);

  // One extra count of headroom so the end-of-active compare value always fits
  localparam int HW = cnt_width(H_TOTAL + 1);
  localparam int VW = cnt_width(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_PW);
  localparam logic [HW-1:0] H_START  = HW'(H_PW + H_BP);
  localparam logic [HW-1:0] H_END    = HW'(H_PW + H_BP + H_DISP);
  localparam logic [HW-1:0] DOT_MASK = HW'(CLK_PER_DOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_PW);
  localparam logic [VW-1:0] V_START  = VW'(V_PW + V_BP);
  localparam logic [VW-1:0] V_END    = VW'(V_PW + V_BP + V_DISP);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [HW-1:0] h_rel;

  // Counter advance plus all decodes of the current raster position
  always_comb begin
    line_end    = (h_cnt_q == H_LAST);
    frame_end   = line_end && (v_cnt_q == V_LAST);
    h_cnt_d     = line_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d     = v_cnt_q;
    if (line_end) begin
      v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
    hs_raw      = !(h_cnt_q < H_SYNC_E);
    vs_raw      = !(v_cnt_q < V_SYNC_E);
    h_active    = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
    v_active    = (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    // CLK_PER_DOT is a power of two, so the dot phase is the low bits of
    // the offset from the start of the active line
    h_rel       = h_cnt_q - H_START;
    dot_end     = h_active && ((h_rel & DOT_MASK) == DOT_MASK);
    frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Raster position registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Scales a BGR555 frame buffer image onto a VGA raster.
//                Generates read addresses incrementally, delays the raster
//                control by the memory read latency and registers the
//                colour and sync outputs together.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_PW        = DEF_H_PW,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_DISP      = DEF_H_DISP,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_PW        = DEF_V_PW,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_DISP      = DEF_V_DISP,
  parameter int CLK_PER_DOT = DEF_CLK_PER_DOT,
  parameter int SRC_COLS    = DEF_SRC_COLS,
  parameter int SRC_ROWS    = DEF_SRC_ROWS,
  parameter int SCALE       = DEF_SCALE,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [14:0]       border,
  input  logic [14:0]       data,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam int               RW         = cnt_width(SRC_ROWS + 1);
  localparam logic [ADDR_W-1:0] SRC_COLS_A = ADDR_W'(SRC_COLS);
  localparam logic [RW-1:0]     SRC_ROWS_R = RW'(SRC_ROWS);
  localparam logic [1:0]        SCALE_LAST = 2'(SCALE - 1);

  logic hs_raw, vs_raw, h_active, v_active;
  logic dot_end, line_end, frame_end, frame_first;

  vga_timing #(
    .H_TOTAL    (H_TOTAL),
    .H_PW       (H_PW),
    .H_BP       (H_BP),
    .H_DISP     (H_DISP),
    .V_TOTAL    (V_TOTAL),
    .V_PW       (V_PW),
    .V_BP       (V_BP),
    .V_DISP     (V_DISP),
    .CLK_PER_DOT(CLK_PER_DOT)
  ) u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .h_active   (h_active),
    .v_active   (v_active),
    .dot_end    (dot_end),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .frame_first(frame_first)
  );

  // Source position state: column within the row, row base address,
  // row index, and repeat counters for the upscale in each axis
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        sub_x_q, sub_x_d;
  logic [1:0]        sub_y_q, sub_y_d;
  logic              en_q, en_d;

  logic img_h, img_v, image;
  scan_ctl_t ctl_s0, ctl_dly;

  // Column walk: restarts every line, steps one source pixel per SCALE dots
  // and parks at SRC_COLS once the image (or the active line) is exhausted
  always_comb begin
    col_d   = col_q;
    sub_x_d = sub_x_q;
    if (!h_active) begin
      col_d   = '0;
      sub_x_d = '0;
    end else if (dot_end && img_h) begin
      if (sub_x_q == SCALE_LAST) begin
        sub_x_d = '0;
        col_d   = col_q + ADDR_W'(1);
      end else begin
        sub_x_d = sub_x_q + 2'(1);
      end
    end
  end

  // Row walk: the base address steps by a full source row after every
  // SCALE-th image line and restarts at the frame wrap
  always_comb begin
    row_d      = row_q;
    sub_y_d    = sub_y_q;
    row_base_d = row_base_q;
    if (frame_end) begin
      row_d      = '0;
      sub_y_d    = '0;
      row_base_d = '0;
    end else if (line_end && img_v) begin
      if (sub_y_q == SCALE_LAST) begin
        sub_y_d    = '0;
        row_d      = row_q + RW'(1);
        row_base_d = row_base_q + SRC_COLS_A;
      end else begin
        sub_y_d    = sub_y_q + 2'(1);
      end
    end
  end

  // Enable is only resampled at dot boundaries (and freely in blanking) so a
  // dot is never split between image and border colour
  always_comb begin
    en_d = en_q;
    if (dot_end || !h_active) begin
      en_d = enable;
    end
  end

  // Source position and enable registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      sub_x_q    <= '0;
      row_q      <= '0;
      sub_y_q    <= '0;
      row_base_q <= '0;
      en_q       <= 1'b0;
    end else begin
      col_q      <= col_d;
      sub_x_q    <= sub_x_d;
      row_q      <= row_d;
      sub_y_q    <= sub_y_d;
      row_base_q <= row_base_d;
      en_q       <= en_d;
    end
  end

  // Image-region decode, read address and the control word for this cycle;
  // the address is held at zero whenever no pixel is being fetched
  always_comb begin
    img_h         = h_active && (col_q < SRC_COLS_A);
    img_v         = v_active && (row_q < SRC_ROWS_R);
    image         = img_h && img_v && en_q;
    addr          = image ? (row_base_q + col_q) : '0;
    ctl_s0        = SCAN_CTL_IDLE;
    ctl_s0.active = h_active && v_active;
    ctl_s0.image  = image;
    ctl_s0.hs     = hs_raw;
    ctl_s0.vs     = vs_raw;
    ctl_s0.fs     = frame_first;
  end

  // Delay the control word by the read latency so it meets the read data
  generate
    if (RD_LAT == 0) begin : g_no_delay
      assign ctl_dly = ctl_s0;
    end else begin : g_delay
      scan_ctl_t pipe_q [RD_LAT];
      scan_ctl_t pipe_d [RD_LAT];

      // Shift the control word one stage per cycle
      always_comb begin
        pipe_d[0] = ctl_s0;
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      // Delay stages reset to the idle control word
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= SCAN_CTL_IDLE;
          end
        end else begin
          for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign ctl_dly = pipe_q[RD_LAT-1];
    end
  endgenerate

  bgr555_t colour_q, colour_d;
  logic    hs_q, hs_d;
  logic    vs_q, vs_d;
  logic    fs_q, fs_d;

  // Colour selection at the aligned stage: blank, image pixel or border
  always_comb begin
    colour_d = '0;
    if (ctl_dly.active) begin
      if (ctl_dly.image) begin
        colour_d = data;
      end else begin
        colour_d = border;
      end
    end
    hs_d = ctl_dly.hs;
    vs_d = ctl_dly.vs;
    fs_d = ctl_dly.fs;
  end

  // Output registers, so colour and syncs leave on the same edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      colour_q <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      colour_q <= colour_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end

  assign vga_r       = colour_q.r[4:1];
  assign vga_g       = colour_q.g[4:1];
  assign vga_b       = colour_q.b[4:1];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;

  // The 4-bit DAC drops the LSB of each 5-bit field
  logic colour_lsb_unused;
  assign colour_lsb_unused = colour_q.r[0] ^ colour_q.g[0] ^ colour_q.b[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout
//  Description : Directed bench for vga_scanout on a small raster.
//                Raster 40 cycles x 16 lines, active h 8..37, v 4..13,
//                2 cycles per dot. Main DUT: 4x2 image at SCALE 3, RD_LAT 1.
//                Second DUT identical at RD_LAT 3 for sync/colour alignment.
//                Third DUT: 20x12 image at SCALE 1, RD_LAT 0, clipped on
//                both the right and bottom edges.
//                Bench cycle k counts rising edges since reset release, so
//                the raster state at k is v = k/40, h = k%40 within a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [14:0] border;

  // Main DUT (RD_LAT 1)
  logic [16:0] addr1;
  logic [14:0] data1;
  logic [3:0]  r1, g1, b1;
  logic        hs1, vs1, fs1;
  // Alignment DUT (RD_LAT 3)
  logic [16:0] addr3;
  logic [14:0] data3, d3_a, d3_b;
  logic [3:0]  r3, g3, b3;
  logic        hs3, vs3, fs3;
  // Clipping DUT (RD_LAT 0)
  logic [16:0] addrc;
  logic [14:0] datac;
  logic [3:0]  rc, gc, bc;
  logic        hsc, vsc, fsc;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [16:0] max_addrc = '0;

  always #5 clock = ~clock;

  vga_scanout #(
    .H_TOTAL(40), .H_PW(4), .H_BP(4), .H_DISP(30),
    .V_TOTAL(16), .V_PW(2), .V_BP(2), .V_DISP(10),
    .CLK_PER_DOT(2), .SRC_COLS(4), .SRC_ROWS(2), .SCALE(3),
    .RD_LAT(1), .ADDR_W(17)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .border(border),
    .data(data1), .addr(addr1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .vga_hs(hs1), .vga_vs(vs1), .frame_start(fs1)
  );

  vga_scanout #(
    .H_TOTAL(40), .H_PW(4), .H_BP(4), .H_DISP(30),
    .V_TOTAL(16), .V_PW(2), .V_BP(2), .V_DISP(10),
    .CLK_PER_DOT(2), .SRC_COLS(4), .SRC_ROWS(2), .SCALE(3),
    .RD_LAT(3), .ADDR_W(17)
  ) u_dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .border(border),
    .data(data3), .addr(addr3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .vga_hs(hs3), .vga_vs(vs3), .frame_start(fs3)
  );

  vga_scanout #(
    .H_TOTAL(40), .H_PW(4), .H_BP(4), .H_DISP(30),
    .V_TOTAL(16), .V_PW(2), .V_BP(2), .V_DISP(10),
    .CLK_PER_DOT(2), .SRC_COLS(20), .SRC_ROWS(12), .SCALE(1),
    .RD_LAT(0), .ADDR_W(17)
  ) u_dutc (
    .clock(clock), .reset_n(reset_n), .enable(enable), .border(border),
    .data(datac), .addr(addrc), .vga_r(rc), .vga_g(gc), .vga_b(bc),
    .vga_hs(hsc), .vga_vs(vsc), .frame_start(fsc)
  );

  // Frame-buffer models: data equals the low address bits, after RD_LAT
  always_ff @(posedge clock) begin
    data1 <= addr1[14:0];
    d3_a  <= addr3[14:0];
    d3_b  <= d3_a;
    data3 <= d3_b;
  end
  assign datac = addrc[14:0];

  // Highest address the clipping DUT ever issues
  always @(negedge clock) begin
    if (reset_n && (addrc > max_addrc)) max_addrc = addrc;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to bench cycle target; sample point is 1 time unit after the edge
  task automatic goto(input int target);
    while (k < target) begin
      @(posedge clock);
      #1;
      k++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    border  = 15'h03E0;   // full green -> vga_g = F

    // ---- reset state ----
    repeat (3) @(posedge clock);
    #1;
    check("rst_hs",     {31'd0, hs1}, 32'd1);
    check("rst_vs",     {31'd0, vs1}, 32'd1);
    check("rst_fs",     {31'd0, fs1}, 32'd0);
    check("rst_colour", {20'd0, b1, g1, r1}, 32'h000);
    check("rst_addr",   {15'd0, addr1}, 32'd0);

    @(negedge clock);
    reset_n = 1'b1;
    k = 0;

    // ---- frame start and sync timing (output latency 2) ----
    goto(1);
    check("fs_early",   {31'd0, fs1}, 32'd0);
    goto(2);
    check("fs_first",   {31'd0, fs1}, 32'd1);
    check("vs_fall",    {31'd0, vs1}, 32'd0);
    check("hs_fall",    {31'd0, hs1}, 32'd0);
    goto(3);
    check("fs_one_cyc", {31'd0, fs1}, 32'd0);
    check("fs3_early",  {31'd0, fs3}, 32'd0);
    check("hs3_early",  {31'd0, hs3}, 32'd1);
    goto(4);
    check("fs3_first",  {31'd0, fs3}, 32'd1);
    check("hs3_fall",   {31'd0, hs3}, 32'd0);
    goto(5);
    check("hs_low_end", {31'd0, hs1}, 32'd0);
    goto(6);
    check("hs_rise",    {31'd0, hs1}, 32'd1);
    goto(81);
    check("vs_low_end", {31'd0, vs1}, 32'd0);
    goto(82);
    check("vs_rise",    {31'd0, vs1}, 32'd1);

    // ---- addresses (combinational from raster state at k) ----
    goto(174);  // v4 h14: dot 3 -> col 1, row 0
    check("addr_v4_c1", {15'd0, addr1}, 32'd1);
    goto(195);  // colour of v4 h33: right border
    check("col_border_r", {20'd0, b1, g1, r1}, 32'h0F0);
    goto(199);  // colour of v4 h37: last active dot, border
    check("col_last_act", {20'd0, b1, g1, r1}, 32'h0F0);
    goto(200);  // colour of v4 h38: blanking
    check("col_hblank", {20'd0, b1, g1, r1}, 32'h000);
    goto(266);  // v6 h26: dot 9 -> col 3, row 0
    check("addr_v6_c3", {15'd0, addr1}, 32'd3);
    goto(284);
    check("hs3_line7",  {31'd0, hs3}, 32'd0);
    goto(288);  // v7 h8: row 1 base
    check("addr_row1",  {15'd0, addr1}, 32'd4);
    goto(289);  // colour of v7 h7: before active
    check("col_pre_act", {20'd0, b1, g1, r1}, 32'h000);
    goto(290);  // colour of v7 h8: addr 4 -> r=2
    check("col_first",  {20'd0, b1, g1, r1}, 32'h002);
    goto(291);
    check("col3_pre",   {20'd0, b3, g3, r3}, 32'h000);
    goto(292);  // RD_LAT 3 DUT: same dot, two cycles later
    check("col3_first", {20'd0, b3, g3, r3}, 32'h002);
    goto(293);  // v7 h13: still col 0
    check("addr_hold",  {15'd0, addr1}, 32'd4);
    goto(294);  // v7 h14: col 1
    check("addr_step",  {15'd0, addr1}, 32'd5);
    goto(312);  // v7 h32: right of image
    check("addr_right0", {15'd0, addr1}, 32'd0);
    goto(393);  // colour of v9 h31: addr 7 -> r=3
    check("col_last_img", {20'd0, b1, g1, r1}, 32'h003);
    goto(408);  // v10 h8: below image
    check("addr_below0", {15'd0, addr1}, 32'd0);
    goto(452);  // colour of v11 h10: bottom border
    check("col_border_b", {20'd0, b1, g1, r1}, 32'h0F0);

    // ---- clipping DUT: last visible dot of last visible line ----
    goto(556);  // v13 h36: row 9, dot 14 -> 9*20+14
    check("clip_addr",  {15'd0, addrc}, 32'd194);
    goto(557);  // 194 -> g5=6, r5=2
    check("clip_colour", {20'd0, bc, gc, rc}, 32'h031);
    goto(558);
    check("clip_addr0", {15'd0, addrc}, 32'd0);
    goto(572);  // colour of v14 h10: vertical blanking
    check("col_vblank", {20'd0, b1, g1, r1}, 32'h000);

    // ---- enable low for frame 1 with blue border ----
    goto(620);
    enable = 1'b0;
    border = 15'h7C00;
    goto(642);
    check("fs_frame1",  {31'd0, fs1}, 32'd1);
    check("vs_frame1",  {31'd0, vs1}, 32'd0);
    check("hs_frame1",  {31'd0, hs1}, 32'd0);
    goto(722);
    check("vs_rise_f1", {31'd0, vs1}, 32'd1);
    goto(930);
    check("dis_first",  {20'd0, b1, g1, r1}, 32'hF00);
    goto(1033);
    check("dis_last",   {20'd0, b1, g1, r1}, 32'hF00);
    goto(1260);
    enable = 1'b1;
    border = 15'h03E0;

    // ---- frame 2: image restored, then asynchronous reset mid-image ----
    goto(1570);
    check("f2_first",   {20'd0, b1, g1, r1}, 32'h002);
    goto(1671);  // state v9 h31; colour of v9 h29
    check("f2_addr",    {15'd0, addr1}, 32'd7);
    check("f2_colour",  {20'd0, b1, g1, r1}, 32'h003);
    check("clip_max",   {15'd0, max_addrc}, 32'd194);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_colour", {20'd0, b1, g1, r1}, 32'h000);
    check("arst_addr",  {15'd0, addr1}, 32'd0);
    check("arst_hs",    {31'd0, hs1}, 32'd1);
    check("arst_vs",    {31'd0, vs1}, 32'd1);
    check("arst_fs",    {31'd0, fs1}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    k = 0;
    goto(1);
    check("rs_fs_early", {31'd0, fs1}, 32'd0);
    goto(2);
    check("rs_fs",      {31'd0, fs1}, 32'd1);
    goto(4);
    check("rs_fs3",     {31'd0, fs3}, 32'd1);
    goto(174);
    check("rs_addr",    {15'd0, addr1}, 32'd1);
    goto(290);
    check("rs_colour",  {20'd0, b1, g1, r1}, 32'h002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_TOTAL, 1596, clock cycles per line including blanking.
REQ-002 Parameter H_PW, 190, hsync pulse width in cycles; H_BP, 95, back porch in cycles; H_DISP, 1280, active cycles per line.
REQ-003 Parameter V_TOTAL, 528, lines per frame; V_PW, 2, vsync width in lines; V_BP, 36, back porch in lines; V_DISP, 480, active lines.
REQ-004 Parameter CLK_PER_DOT, 2, clock cycles per output dot (power of two, 1..8).
REQ-005 Parameter SRC_COLS, 240 and SRC_ROWS, 160, source image size in pixels.
REQ-006 Parameter SCALE, 2, integer upscale factor (1..4) applied in both axes.
REQ-007 Parameter RD_LAT, 1, frame-buffer read latency in cycles (0..3); ADDR_W, 17, address width.
REQ-008 clock  in  1  system clock; all logic on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 enable  in  1  when low, image region output as border colour; timing keeps running.
REQ-011 border  in  15  BGR555 colour for active-but-off-image dots.
REQ-012 data  in  15  BGR555 frame-buffer read data, valid RD_LAT cycles after addr.
REQ-013 addr  out  ADDR_W  frame-buffer read address.
REQ-014 vga_r, vga_g, vga_b  out  4 each  colour outputs (5-bit field MSBs: R=[4:1], G=[9:6], B=[14:11]).
REQ-015 vga_hs, vga_vs  out  1 each  active-low sync outputs.
REQ-016 frame_start  out  1  one-cycle pulse at start of each frame (aligned with vga_vs falling edge).

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 every cycle and wrap; v_cnt SHALL advance (wrapping at V_TOTAL-1 -> 0) only in the cycle h_cnt==H_TOTAL-1.
REQ-018 Raw hsync SHALL be low while h_cnt<H_PW; raw vsync low while v_cnt<V_PW.
REQ-019 Active region: H_PW+H_BP <= h_cnt < H_PW+H_BP+H_DISP and V_PW+V_BP <= v_cnt < V_PW+V_BP+V_DISP; outside it colour SHALL be 0.
REQ-020 Dot x = (h_cnt-HSTART)/CLK_PER_DOT, line y = v_cnt-VSTART; image region x < SRC_COLS*SCALE and y < SRC_ROWS*SCALE, placed top-left.
REQ-021 In image region with enable high, addr SHALL equal (y/SCALE)*SRC_COLS + x/SCALE, generated incrementally by row-base accumulator and column counter; no multiplier or divider.
REQ-022 Row base SHALL add SRC_COLS after every SCALE-th image line ends and clear to 0 at frame wrap.
REQ-023 Outside image region addr SHALL be 0 (no out-of-range reads).
REQ-024 Outputs (colour, vga_hs, vga_vs, frame_start) SHALL be registered with total latency RD_LAT+1 cycles from counter state, so sync and colour stay aligned for any RD_LAT.
REQ-025 In active region: image and enable -> data fields; otherwise -> border fields.
REQ-026 Parameter values where image exceeds H_DISP/CLK_PER_DOT or V_DISP SHALL be clipped at active edge; address never exceeds SRC_COLS*SRC_ROWS-1.
REQ-027 enable changes SHALL take effect on next dot boundary; no counter disturbance.

Reset
REQ-028 Under reset_n low: h_cnt, v_cnt, row base, column counter, addr = 0; colour = 0; vga_hs = vga_vs = 1; frame_start = 0; delay pipeline cleared to inactive values.
REQ-029 Reset mid-frame SHALL restart timing at h_cnt=v_cnt=0; first frame_start RD_LAT+1 cycles after release.

Structure
REQ-030 Shared package vga_pkg SHALL hold the BGR555 colour struct typedef and default GBA/640x480 timing constants.
REQ-031 One sub-module vga_timing (counters, raw syncs, active flag, dot/line strobes); scanout, address and alignment pipeline in vga_scanout.

Verification
REQ-032 Defaults, RD_LAT=1, one full frame -> hs period 1596 cycles low 190; vs low 2 lines; frame_start every 842688 cycles.
REQ-033 Defaults, memory model data=addr[14:0] -> first image dot colour from addr 0; last image dot of line 319 uses addr 38399; addr 0 outside image.
REQ-034 Sweep RD_LAT 0..3 -> vga_hs falling edge to first active colour offset identical (HSTART cycles) in all cases.
REQ-035 SCALE=3, SRC_COLS=4, SRC_ROWS=2, small timing -> each address held 3*CLK_PER_DOT cycles, each row repeated 3 lines, border colour right/below image.
REQ-036 enable low for one frame, border=15'h7C00 -> all active dots vga_b=4'hF, vga_r=vga_g=0; syncs unchanged.
REQ-037 reset_n pulsed low at v_cnt=200 -> outputs reach reset values asynchronously; frame_start after release at cycle RD_LAT+1.
